cuenta1: RTL and testbench
==========================

CUENTA1 -- requirements
Module: cuenta1

Interface
REQ-001 Parameter: N, default 3, width of entrada (number of bits examined).
REQ-002 Parameter: CW, default 4, width of salida; SHALL satisfy 2**CW > N.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: entrada  input  N  operand whose '1' bits are counted; sampled only on the accepting start edge.
REQ-006 Port: start  input  1  request to begin a count; level-sampled on rising clk.
REQ-007 Port: salida  output  CW  running/final count of '1' bits, registered.
REQ-008 Port: fin  output  1  result-valid flag, registered.
REQ-009 Positional port order SHALL be entrada, start, clk, salida, fin, rst_n.

Function
REQ-010 FSM states SHALL be IDLE, COUNT, DONE.
REQ-011 IDLE: fin=0; start=1 at an edge -> load entrada into internal shift register, clear salida to 0, load bit counter with N, go to COUNT.
REQ-012 COUNT: each edge, if shift-register LSB=1 then salida <= salida+1; shift right by one (zero fill); bit counter decrements.
REQ-013 COUNT -> DONE on the edge that processes the Nth bit; fin=1 from that edge onward.
REQ-014 Latency: fin SHALL rise exactly N clock edges after the edge that accepted start; salida is final at that same edge.
REQ-015 start SHALL be ignored while in COUNT; entrada changes after acceptance SHALL NOT affect the result.
REQ-016 DONE: salida and fin held stable; start=1 -> reload as in REQ-011 (fin drops to 0 that edge); start=0 -> stay in DONE.
REQ-017 salida SHALL never exceed N; no wrap-around possible with legal parameters.
REQ-018 entrada all zeros SHALL yield salida=0 with normal latency; all ones SHALL yield salida=N.
REQ-019 start held high continuously SHALL cause a new count every N+1 edges (IDLE/DONE accept, N COUNT edges).

Reset
REQ-020 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, salida=0, fin=0, shift register=0, bit counter=0.
REQ-021 Reset asserted mid-COUNT SHALL abort the count; no fin pulse follows.
REQ-022 After rst_n deasserts, first start acceptance occurs at the first rising edge with start=1 and rst_n=1.

Structure
REQ-023 Package cuenta1_pkg SHALL hold the state enumeration (IDLE, COUNT, DONE) and default widths N=3, CW=4.
REQ-024 Single module; FSM and datapath (shift register, bit counter, salida accumulator) in cuenta1, no sub-module.

Verification
REQ-025 Reset, then entrada=101, start=1 for one edge -> salida=0 next edge; after 3 edges fin=1, salida=0010.
REQ-026 entrada=000 accepted -> fin=1 after 3 edges, salida=0000; entrada=111 -> salida=0011.
REQ-027 Accept entrada=110, change entrada to 001 and pulse start during COUNT -> result still salida=0010, fin timing unchanged.
REQ-028 In DONE with salida=0010, start=1 with entrada=001 -> fin=0, salida=0 next edge; 3 edges later fin=1, salida=0001.
REQ-029 Assert rst_n=0 between clock edges mid-COUNT -> salida=0, fin=0 immediately; no fin after release without new start.
REQ-030 Hold start=1 with entrada=101 for 10 cycles -> fin high every 4th edge, salida=0010 each time.

Source files
------------

// File: rtl/cuenta1_pkg.sv
// Shared definitions for the cuenta1 serial ones-counter.
// Holds the FSM state type and the default operand and result widths.
package cuenta1_pkg;

   localparam int N_DEF  = 3;
   localparam int CW_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/cuenta1.sv
// Serial ones-counter: latches entrada on start, then examines one bit per clock.
// fin rises N edges after acceptance, and salida then holds the number of '1' bits.
module cuenta1
   import cuenta1_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int CW = CW_DEF
) (
   input  logic [N-1:0]  entrada,
   input  logic          start,
   input  logic          clk,
   output logic [CW-1:0] salida,
   output logic          fin,
   input  logic          rst_n
);

   localparam int BW = $clog2(N + 1);

   state_t         state_reg,  state_next;
   logic [N-1:0]   shift_reg,  shift_next;
   logic [BW-1:0]  bits_reg,   bits_next;
   logic [CW-1:0]  salida_reg, salida_next;
   logic           fin_reg,    fin_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         shift_reg  <= '0;
         bits_reg   <= '0;
         salida_reg <= '0;
         fin_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         shift_reg  <= shift_next;
         bits_reg   <= bits_next;
         salida_reg <= salida_next;
         fin_reg    <= fin_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      shift_next  = shift_reg;
      bits_next   = bits_reg;
      salida_next = salida_reg;
      fin_next    = fin_reg;

      case (state_reg)
         IDLE, DONE: begin
            // DONE holds its result until a new start reloads everything.
            if (start) begin
               shift_next  = entrada;
               bits_next   = BW'(N);
               salida_next = '0;
               fin_next    = 1'b0;
               state_next  = COUNT;
            end
         end
         COUNT: begin
            if (shift_reg[0])
               salida_next = salida_reg + CW'(1);
            shift_next = shift_reg >> 1;
            bits_next  = bits_reg - BW'(1);
            if (bits_reg == BW'(1)) begin
               fin_next   = 1'b1;
               state_next = DONE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign salida = salida_reg;
   assign fin    = fin_reg;

endmodule

// File: tb/tb_cuenta1.sv
// Directed and random checks of cuenta1 against a transaction-level model:
// an accepted operand, and the number of its bits examined so far.
module tb_cuenta1;

   localparam int N  = 3;
   localparam int CW = 4;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          start   = 1'b0;
   logic [N-1:0]  entrada = '0;
   logic [CW-1:0] salida;
   logic          fin;

   int total = 0;
   int bad   = 0;

   // model: an accepted operand plus how many of its bits have been examined
   bit           m_active = 1'b0;
   int           m_k      = 0;
   logic [N-1:0] m_op     = '0;
   int           m_done   = 0;

   cuenta1 #(.N(N), .CW(CW)) dut (
      .entrada(entrada),
      .start  (start),
      .clk    (clk),
      .salida (salida),
      .fin    (fin),
      .rst_n  (rst_n)
   );

   always #5 clk = ~clk;

   function automatic int ones_low(logic [N-1:0] v, int k);
      int s = 0;
      for (int i = 0; i < k; i++)
         if (v[i]) s++;
      return s;
   endfunction

   function automatic int exp_salida();
      return m_active ? ones_low(m_op, m_k) : 0;
   endfunction

   function automatic int exp_fin();
      return (m_active && m_k == N) ? 1 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_salida"}, 32'(salida), 32'(exp_salida()));
      chk({tag, "_fin"},    32'(fin),    32'(exp_fin()));
   endtask

   // one clock: drive inputs, take the edge, update the model, sample at the negedge
   task automatic step(input string tag, input logic s, input logic [N-1:0] e);
      start   = s;
      entrada = e;
      @(posedge clk);
      if (rst_n) begin
         if ((!m_active || m_k == N) && s) begin
            m_active = 1'b1;
            m_op     = e;
            m_k      = 0;
         end else if (m_active && m_k < N) begin
            m_k++;
         end
      end
      @(negedge clk);
      check_outputs(tag);
      if (exp_fin() == 1 && m_k == N && m_done == 0) begin
         $display("txn op=%b ones=%0d salida=%0d fin=%0d", m_op, ones_low(m_op, N), salida, fin);
         m_done = 1;
      end
      if (exp_fin() == 0) m_done = 0;
   endtask

   // asserts reset between edges and checks the outputs clear before any clock
   task automatic async_reset(input string tag);
      #2;
      rst_n    = 1'b0;
      m_active = 1'b0;
      m_k      = 0;
      #1;
      check_outputs(tag);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      // reset state while rst_n is low from time zero
      #2;
      chk("reset_salida", 32'(salida), 32'd0);
      chk("reset_fin",    32'(fin),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 101: running count, then final result after three edges
      step("r25_acc", 1'b1, 3'b101);
      chk("r25_acc_zero", 32'(salida), 32'd0);
      step("r25_c1", 1'b0, 3'b000);
      step("r25_c2", 1'b0, 3'b000);
      chk("r25_not_yet", 32'(fin), 32'd0);
      step("r25_c3", 1'b0, 3'b000);
      chk("r25_final", 32'({fin, salida}), 32'({1'b1, 4'b0010}));

      // all zeros, then all ones
      step("r26a_acc", 1'b1, 3'b000);
      for (int i = 0; i < N; i++) step("r26a", 1'b0, 3'b111);
      chk("r26_zeros", 32'({fin, salida}), 32'({1'b1, 4'b0000}));
      step("r26b_acc", 1'b1, 3'b111);
      for (int i = 0; i < N; i++) step("r26b", 1'b0, 3'b000);
      chk("r26_ones", 32'({fin, salida}), 32'({1'b1, 4'b0011}));

      // entrada changes and start pulses during COUNT are ignored
      step("r27_acc", 1'b1, 3'b110);
      for (int i = 0; i < N; i++) step("r27", 1'b1, 3'b001);
      chk("r27_final", 32'({fin, salida}), 32'({1'b1, 4'b0010}));
      step("r27_hold", 1'b0, 3'b111);
      step("r27_hold2", 1'b0, 3'b000);

      // restart from DONE
      step("r28_acc", 1'b1, 3'b001);
      chk("r28_drop", 32'({fin, salida}), 32'd0);
      for (int i = 0; i < N; i++) step("r28", 1'b0, 3'b000);
      chk("r28_final", 32'({fin, salida}), 32'({1'b1, 4'b0001}));

      // asynchronous reset in the middle of a count
      step("r29_acc", 1'b1, 3'b111);
      step("r29_c1", 1'b0, 3'b000);
      async_reset("r29_rst");
      for (int i = 0; i < N + 2; i++) step("r29_idle", 1'b0, 3'b111);
      chk("r29_no_fin", 32'(fin), 32'd0);

      // start held high: a new count every N+1 edges
      for (int i = 0; i < 10; i++) step("r30", 1'b1, 3'b101);

      // random traffic with occasional mid-cycle resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0)
            async_reset("rnd_rst");
         step("rnd", ($urandom_range(0, 2) == 0), N'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
